// File: rtl/ex_alu_mdu.sv
// Execute-stage datapath: forwarding muxes, single-cycle ALU and an optional
// iterative multiply/divide unit enabled by defining EX_ALU_MDU_EN.
module ex_alu_mdu #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            ex_flush,
    input  logic [1:0]      ex_fwd1,
    input  logic [1:0]      ex_fwd2,
    input  logic [XLEN-1:0] ex_rdata1,
    input  logic [XLEN-1:0] ex_rdata_mux,
    input  logic [XLEN-1:0] wb_wdata,
    input  logic [XLEN-1:0] mem_alu_result,
    input  logic [3:0]      ex_aluctl,
    output logic [XLEN-1:0] ex_alu_result,
    output logic            ex_zero,
    output logic            ex_stall,
    output logic            ex_mdu_done
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_SLTU = 4'b1101;

    function automatic logic [XLEN-1:0] fwd_pick(input logic [1:0] sel,
                                                 input logic [XLEN-1:0] reg_val,
                                                 input logic [XLEN-1:0] wb_val,
                                                 input logic [XLEN-1:0] mem_val);
        case (sel)
            2'd0:    fwd_pick = reg_val;
            2'd1:    fwd_pick = wb_val;
            2'd2:    fwd_pick = mem_val;
            default: fwd_pick = '0;
        endcase
    endfunction

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] mdu_result;
    logic            is_mdu_op;
    logic            mdu_idle;

    assign op_a = fwd_pick(ex_fwd1, ex_rdata1, wb_wdata, mem_alu_result);
    assign op_b = fwd_pick(ex_fwd2, ex_rdata_mux, wb_wdata, mem_alu_result);

    always_comb begin
        alu_out = '0;
        case (ex_aluctl)
            OP_AND:  alu_out = op_a & op_b;
            OP_OR:   alu_out = op_a | op_b;
            OP_ADD:  alu_out = op_a + op_b;
            OP_SUB:  alu_out = op_a - op_b;
            OP_NOR:  alu_out = ~(op_a | op_b);
            OP_SLT:  alu_out = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: alu_out = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            default: alu_out = '0;
        endcase
    end

`ifdef EX_ALU_MDU_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    state_t          state;
    state_t          state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic [XLEN-1:0] opnd;
    logic [1:0]      mdu_op;
    logic            issue;

    // Multiply: {acc_hi, acc_lo} holds partial product over multiplier; shift right each step.
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_hi;
    logic [XLEN-1:0] mul_lo;
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    assign mul_hi  = mul_sum[XLEN:1];
    assign mul_lo  = {mul_sum[0], acc_lo[XLEN-1:1]};

    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    logic [XLEN:0]   div_shift;
    logic            div_ok;
    logic [XLEN-1:0] div_hi;
    logic [XLEN-1:0] div_lo;
    assign div_shift = {acc_hi, acc_lo[XLEN-1]};
    assign div_ok    = (div_shift >= {1'b0, opnd});
    assign div_hi    = div_ok ? (div_shift[XLEN-1:0] - opnd) : div_shift[XLEN-1:0];
    assign div_lo    = {acc_lo[XLEN-2:0], div_ok};

    assign is_mdu_op  = (ex_aluctl[3:2] == 2'b10);
    assign issue      = (state == IDLE) && ex_valid && is_mdu_op && !ex_flush;
    assign mdu_idle   = (state == IDLE);
    assign mdu_result = mdu_op[0] ? acc_hi : acc_lo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ex_stall    = 1'b0;
        ex_mdu_done = 1'b0;
        case (state)
            IDLE: begin
                if (issue) begin
                    state_nxt = BUSY;
                    ex_stall  = 1'b1;
                end
            end
            BUSY: begin
                if (ex_flush) begin
                    state_nxt = IDLE;
                end else begin
                    ex_stall = 1'b1;
                    if (cnt == CNT_LAST) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt   = IDLE;
                ex_mdu_done = !ex_flush;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            mdu_op <= '0;
        end else if (issue) begin
            cnt    <= '0;
            mdu_op <= ex_aluctl[1:0];
            acc_hi <= '0;
            acc_lo <= ex_aluctl[1] ? op_a : op_b;
            opnd   <= ex_aluctl[1] ? op_b : op_a;
        end else if (state == BUSY) begin
            cnt    <= cnt + 1'b1;
            acc_hi <= mdu_op[1] ? div_hi : mul_hi;
            acc_lo <= mdu_op[1] ? div_lo : mul_lo;
        end
    end
`else
    logic             unused_ports;
    logic [CNT_W-1:0] unused_cnt;
    assign unused_ports = ^{clk, rst_n, ex_flush};
    assign unused_cnt   = '0;
    assign is_mdu_op    = 1'b0;
    assign mdu_idle     = 1'b1;
    assign mdu_result   = '0;
    assign ex_stall     = 1'b0;
    assign ex_mdu_done  = 1'b0;
`endif

    // Result is only meaningful for a live single-cycle op in IDLE or a presented MDU result.
    always_comb begin
        ex_alu_result = '0;
        ex_zero       = 1'b0;
        if (ex_mdu_done) begin
            ex_alu_result = mdu_result;
            ex_zero       = (mdu_result == '0);
        end else if (mdu_idle && ex_valid && !is_mdu_op) begin
            ex_alu_result = alu_out;
            ex_zero       = (alu_out == '0);
        end
    end

endmodule

// File: tb/tb_ex_alu_mdu.sv
// Self-checking bench for ex_alu_mdu: table-driven ALU/forwarding vectors plus
// MDU latency, abort and reset sequences when EX_ALU_MDU_EN is defined.
module tb_ex_alu_mdu;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ex_valid = 1'b0;
    logic            ex_flush = 1'b0;
    logic [1:0]      ex_fwd1 = '0;
    logic [1:0]      ex_fwd2 = '0;
    logic [XLEN-1:0] ex_rdata1 = '0;
    logic [XLEN-1:0] ex_rdata_mux = '0;
    logic [XLEN-1:0] wb_wdata = '0;
    logic [XLEN-1:0] mem_alu_result = '0;
    logic [3:0]      ex_aluctl = '0;
    logic [XLEN-1:0] ex_alu_result;
    logic            ex_zero;
    logic            ex_stall;
    logic            ex_mdu_done;

    int errors = 0;
    int checks = 0;

    ex_alu_mdu #(.XLEN(XLEN)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_flush       (ex_flush),
        .ex_fwd1        (ex_fwd1),
        .ex_fwd2        (ex_fwd2),
        .ex_rdata1      (ex_rdata1),
        .ex_rdata_mux   (ex_rdata_mux),
        .wb_wdata       (wb_wdata),
        .mem_alu_result (mem_alu_result),
        .ex_aluctl      (ex_aluctl),
        .ex_alu_result  (ex_alu_result),
        .ex_zero        (ex_zero),
        .ex_stall       (ex_stall),
        .ex_mdu_done    (ex_mdu_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic            valid;
        logic [3:0]      ctl;
        logic [1:0]      f1;
        logic [1:0]      f2;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] wb;
        logic [XLEN-1:0] mem;
        logic [XLEN-1:0] res;
        logic            zero;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic v, input logic [3:0] ctl, input logic [1:0] f1, input logic [1:0] f2,
                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [XLEN-1:0] wb, input logic [XLEN-1:0] mem,
                           input logic [XLEN-1:0] res, input logic zero);
        vec_t t;
        t.valid = v; t.ctl = ctl; t.f1 = f1; t.f2 = f2;
        t.a = a; t.b = b; t.wb = wb; t.mem = mem; t.res = res; t.zero = zero;
        vecs.push_back(t);
    endtask

    task automatic run_mdu(input string name, input logic [3:0] op, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp);
        int stall_cycles;
        int done_seen;
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_flush = 1'b0; ex_aluctl = op;
        ex_fwd1 = 2'd0; ex_fwd2 = 2'd0; ex_rdata1 = a; ex_rdata_mux = b;
        #1;
        stall_cycles = 0;
        done_seen = 0;
        while (ex_stall && stall_cycles < 100) begin
            stall_cycles++;
            if (ex_mdu_done) done_seen++;
            @(posedge clk); #1;
            ex_rdata1 = $urandom;
            ex_rdata_mux = $urandom;
            #1;
        end
        check({name, "_stall_cycles"}, stall_cycles, XLEN + 1);
        check({name, "_early_done"}, done_seen, 0);
        check({name, "_done"}, ex_mdu_done, 1'b1);
        check({name, "_result"}, ex_alu_result, exp);
        check({name, "_zero"}, ex_zero, exp == '0);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        #1;
        check({name, "_done_once"}, ex_mdu_done, 1'b0);
        check({name, "_stall_after"}, ex_stall, 1'b0);
    endtask

    initial begin
        int done_seen;
        int stall_seen;

        // valid, ctl, fwd1, fwd2, A, B, wb_wdata, mem_alu_result, expected result, expected zero
        add_vec(1, 4'b0010, 2, 1, 32'd5, 32'd7, 32'd100, 32'd200, 32'd300, 0);
        add_vec(1, 4'b0010, 1, 2, 32'd5, 32'd7, 32'd100, 32'd200, 32'd300, 0);
        add_vec(1, 4'b0110, 0, 0, 32'd7, 32'd7, 32'd100, 32'd200, 32'd0, 1);
        add_vec(1, 4'b0111, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd1, 0);
        add_vec(1, 4'b1101, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0, 1);
        add_vec(1, 4'b0111, 0, 0, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 1);
        add_vec(1, 4'b1101, 0, 0, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd1, 0);
        add_vec(1, 4'b0000, 0, 0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'd0, 32'hF000_F000, 0);
        add_vec(1, 4'b0001, 0, 0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'd0, 32'hFFF0_FFF0, 0);
        add_vec(1, 4'b1100, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 0);
        add_vec(1, 4'b0010, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0, 1);
        add_vec(1, 4'b0110, 0, 0, 32'd0, 32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF, 0);
        add_vec(1, 4'b0010, 3, 3, 32'd5, 32'd7, 32'd100, 32'd200, 32'd0, 1);
        add_vec(1, 4'b0011, 0, 0, 32'd5, 32'd7, 32'd0, 32'd0, 32'd0, 1);
        add_vec(0, 4'b0010, 0, 0, 32'd5, 32'd7, 32'd0, 32'd0, 32'd0, 0);
`ifndef EX_ALU_MDU_EN
        add_vec(1, 4'b1000, 0, 0, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 32'd0, 1);
        add_vec(1, 4'b1010, 0, 0, 32'd100, 32'd7, 32'd0, 32'd0, 32'd0, 1);
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check("reset_result", ex_alu_result, '0);
        check("reset_zero", ex_zero, 1'b0);
        check("reset_stall", ex_stall, 1'b0);
        check("reset_done", ex_mdu_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            ex_valid = vecs[i].valid; ex_aluctl = vecs[i].ctl;
            ex_fwd1 = vecs[i].f1; ex_fwd2 = vecs[i].f2;
            ex_rdata1 = vecs[i].a; ex_rdata_mux = vecs[i].b;
            wb_wdata = vecs[i].wb; mem_alu_result = vecs[i].mem;
            #1;
            check($sformatf("vec%0d_result", i), ex_alu_result, vecs[i].res);
            check($sformatf("vec%0d_zero", i), ex_zero, vecs[i].zero);
            check($sformatf("vec%0d_stall", i), ex_stall, 1'b0);
            check($sformatf("vec%0d_done", i), ex_mdu_done, 1'b0);
        end
        @(negedge clk);
        ex_valid = 1'b0;
        ex_fwd1 = 2'd0;
        ex_fwd2 = 2'd0;

`ifdef EX_ALU_MDU_EN
        run_mdu("mul", 4'b1000, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
        run_mdu("mulhu", 4'b1001, 32'hFFFF_FFFF, 32'd2, 32'd1);
        run_mdu("mul_small", 4'b1000, 32'd12345, 32'd6789, 32'd83810205);
        run_mdu("divu", 4'b1010, 32'd100, 32'd7, 32'd14);
        run_mdu("remu", 4'b1011, 32'd100, 32'd7, 32'd2);
        run_mdu("divu_zero", 4'b1010, 32'd9, 32'd0, 32'hFFFF_FFFF);
        run_mdu("remu_zero", 4'b1011, 32'd9, 32'd0, 32'd9);

        // Flush at BUSY cycle 10
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_aluctl = 4'b1000; ex_rdata1 = 32'd3; ex_rdata_mux = 32'd4;
        repeat (10) @(posedge clk);
        #1;
        ex_flush = 1'b1;
        @(posedge clk); #1;
        ex_flush = 1'b0;
        ex_valid = 1'b0;
        #1;
        check("flush_stall_drop", ex_stall, 1'b0);
        check("flush_result", ex_alu_result, '0);
        done_seen = 0;
        stall_seen = 0;
        repeat (40) begin
            @(posedge clk); #2;
            if (ex_mdu_done) done_seen++;
            if (ex_stall) stall_seen++;
        end
        check("flush_no_done", done_seen, 0);
        check("flush_no_stall", stall_seen, 0);

        // Reset mid-BUSY
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_aluctl = 4'b1010; ex_rdata1 = 32'd100; ex_rdata_mux = 32'd7;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        ex_valid = 1'b0;
        #1;
        check("rst_mid_result", ex_alu_result, '0);
        check("rst_mid_zero", ex_zero, 1'b0);
        check("rst_mid_stall", ex_stall, 1'b0);
        check("rst_mid_done", ex_mdu_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        stall_seen = 0;
        repeat (40) begin
            @(posedge clk); #2;
            if (ex_mdu_done) done_seen++;
            if (ex_stall) stall_seen++;
        end
        check("rst_no_done", done_seen, 0);
        check("rst_no_stall", stall_seen, 0);
        run_mdu("remu_after_rst", 4'b1011, 32'd100, 32'd7, 32'd2);
`else
        // MDU absent: a held MUL never stalls and yields 0
        @(negedge clk);
        ex_valid = 1'b1; ex_aluctl = 4'b1000; ex_rdata1 = 32'hFFFF_FFFF; ex_rdata_mux = 32'd2;
        done_seen = 0;
        stall_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ex_mdu_done) done_seen++;
            if (ex_stall) stall_seen++;
        end
        check("nomdu_stall", stall_seen, 0);
        check("nomdu_done", done_seen, 0);
        check("nomdu_result", ex_alu_result, '0);
        ex_valid = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/ex_alu_mdu.md
# ex_alu_mdu

Parametrised execute-stage datapath: two forwarding operand muxes feeding an XLEN-wide ALU, plus an iterative multiply/divide unit (MDU) that holds the pipeline while it runs. Sits in EX between the ID/EX and EX/MEM pipeline registers. Single-cycle ALU ops stay combinational. MDU ops take a fixed number of cycles, with a stall handshake back to the hazard unit.

## Interface
- XLEN, 32: datapath width. Must be ≥ 8.
- CNT_W, $clog2(XLEN)+1: iteration counter width.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  live instruction present in EX
- ex_flush  in  1  kill the instruction in EX; abort any MDU operation
- ex_fwd1, ex_fwd2  in  2 each  operand select: 0 = register/immediate value, 1 = wb_wdata, 2 = mem_alu_result, 3 = treated as 0
- ex_rdata1  in  XLEN  register operand A
- ex_rdata_mux  in  XLEN  register/immediate operand B
- wb_wdata  in  XLEN  WB-stage write-back data
- mem_alu_result  in  XLEN  MEM-stage ALU result
- ex_aluctl  in  4  operation code
- ex_alu_result  out  XLEN  result
- ex_zero  out  1  result == 0
- ex_stall  out  1  hold IF/ID/EX; EX/MEM gets a bubble
- ex_mdu_done  out  1  one-cycle pulse when an MDU result is presented

## Operation
- Operands A and B come from the forwarding muxes (ex_fwd1 selects A, ex_fwd2 selects B).
- Single-cycle ops, with result widths of XLEN:
  - 0000 AND, 0001 OR, 0010 ADD (wraps), 0110 SUB (wraps), 1100 NOR
  - 0111 SLT: signed compare, result 1 or 0
  - 1101 SLTU: unsigned compare, result 1 or 0
- MDU ops (unsigned):
  - 1000 MUL: low XLEN bits of A×B
  - 1001 MULHU: high XLEN bits of A×B
  - 1010 DIVU: quotient
  - 1011 REMU: remainder
- Undefined codes: result 0, no stall.
- MDU state machine:
  - IDLE → BUSY when ex_valid & MDU op & !ex_flush. Operands latch into internal registers, counter = 0.
  - BUSY: one shift-add (multiply) or restoring-subtract (divide) step per cycle. Counter increments; at counter == XLEN−1 → DONE.
  - DONE: ex_alu_result = latched MDU result, ex_mdu_done = 1, ex_stall = 0. Always → IDLE next cycle.
  - ex_flush in BUSY or DONE → IDLE next cycle, no done pulse.
- Divide by zero: quotient = all ones, remainder = A. Full latency is still spent.
- While ex_valid = 0 or in BUSY: ex_alu_result = 0, ex_zero = 0.
- ex_zero = (ex_alu_result == 0) only when the result is valid: ex_valid with a single-cycle/undefined op in IDLE, or DONE.

## Timing
- Reset (async assert, sync deassert by the surrounding design):
  - state = IDLE, counter = 0, MDU registers = 0
  - ex_stall = 0, ex_mdu_done = 0, ex_alu_result = 0, ex_zero = 0
- Single-cycle ops: zero latency, combinational from inputs.
- MDU op issued at cycle T:
  - ex_stall = 1 combinationally during T through T+XLEN (BUSY covers T+1..T+XLEN)
  - DONE at T+XLEN+1: stall low, result valid, pipeline advances at the end of that cycle
  - Occupancy: XLEN+2 cycles in EX
- ex_stall is a combinational function of state, ex_valid, ex_aluctl and ex_flush. No dependency on the hazard unit's response.
- Forwarding inputs may change during BUSY; latched operands are used.
- DONE followed by a new MDU op: the new op issues from IDLE on the following cycle. No back-to-back issue from DONE.
- Reset mid-operation: immediate return to IDLE. No done pulse.

## Configuration
- EX_ALU_MDU_EN defined: MDU, codes 1000–1011 and ex_stall/ex_mdu_done behave as above.
- Undefined: no MDU logic; codes 1000–1011 act as undefined (result 0); ex_stall and ex_mdu_done are tied to 0.

## Test plan
- Forwarding: A = 5, B = 7, wb_wdata = 100, mem_alu_result = 200, ADD with fwd1 = 2, fwd2 = 1 → result 300, zero 0, no stall. SUB with fwd = 0 and A = B = 7 → 0, zero 1.
- SLT/SLTU: A = 0xFFFFFFFF, B = 1 → SLT 1, SLTU 0.
- MUL/MULHU, A = 0xFFFFFFFF, B = 2:
  - stall high for 33 cycles (XLEN = 32)
  - then one DONE cycle: MUL → 0xFFFFFFFE, MULHU → 1, ex_mdu_done pulses once
- DIVU 100/7 → 14, REMU → 2. DIVU x/0 with A = 9 → 0xFFFFFFFF; REMU → 9. Both take full latency.
- Abort: ex_flush at BUSY cycle 10 → IDLE next cycle, stall drops, no done pulse. rst_n low mid-BUSY → all outputs 0 immediately.
- Build without EX_ALU_MDU_EN: MUL op → result 0, ex_stall never asserts.
